mixer_mac_sched: RTL

Time-multiplexed mix scheduler for the mixer datapath: accepts one frame of NUM_CH signed channel samples, sequences them one per cycle through a single shared registered signed multiplier against per-channel gains, accumulates, then rounds, saturates and emits one mixed sample. It sits between the per-voice sample sources and the output stage, and replaces NUM_CH parallel multipliers with one.

---
 rtl/mixer_pkg.sv | 34 +++
 rtl/mixer_mul_reg.sv | 36 +++
 rtl/mixer_mac_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared types and width/limit helpers for the time-multiplexed mixer.
// Everything here is parameter-agnostic so the top can derive its own sizes.
package mixer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SAT   = 3'd3,
    ST_OUT   = 3'd4
  } mix_state_e;

  function automatic int prod_width(input int samp_w, input int gain_w);
    return samp_w + gain_w;
  endfunction

  // Summing num_ch full-scale products needs clog2(num_ch) guard bits.
  function automatic int acc_width(input int samp_w, input int gain_w, input int num_ch);
    return samp_w + gain_w + $clog2(num_ch);
  endfunction

  function automatic longint sat_max(input int samp_w);
    return (64'sd1 <<< (samp_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int samp_w);
    return -(64'sd1 <<< (samp_w - 1));
  endfunction

  localparam int     DEF_SAMP_W  = 24;
  localparam longint SAT_MAX_DEF = sat_max(DEF_SAMP_W);
  localparam longint SAT_MIN_DEF = sat_min(DEF_SAMP_W);

endpackage

// File: rtl/mixer_mul_reg.sv
// Registered signed multiplier shared by all channels; one cycle of latency,
// with a valid bit travelling alongside the product.
module mixer_mul_reg #(
  parameter int A_W = 24,
  parameter int B_W = 13,
  parameter int P_W = A_W + B_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic                  out_valid,
  output logic signed [P_W-1:0] p
);

  logic signed [P_W-1:0] a_ext_s;
  logic signed [P_W-1:0] b_ext_s;
  logic signed [P_W-1:0] prod_s;

  assign a_ext_s = {{(P_W-A_W){a[A_W-1]}}, a};
  assign b_ext_s = {{(P_W-B_W){b[B_W-1]}}, b};
  assign prod_s  = a_ext_s * b_ext_s;

  // Product and valid pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= {P_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      p         <= prod_s;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/mixer_mac_sched.sv
// Mix scheduler: accepts a frame of channel samples, runs them one per cycle
// through the shared multiplier against the gain file, then rounds/saturates.
module mixer_mac_sched
  import mixer_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int SAMP_W    = 24,
  parameter int GAIN_W    = 13,
  parameter int GAIN_FRAC = 11
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [NUM_CH*SAMP_W-1:0]  s_samples,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [SAMP_W-1:0]         m_data,
  output logic                      m_sat,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [GAIN_W-1:0]         cfg_gain
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PROD_W = prod_width(SAMP_W, GAIN_W);
  localparam int ACC_W  = acc_width(SAMP_W, GAIN_W, NUM_CH);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(SAMP_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(SAMP_W));
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(64'sd1 <<< (GAIN_FRAC - 1));

  mix_state_e                state_r;
  mix_state_e                state_nxt_s;
  logic [CH_W-1:0]           ch_r;
  logic signed [SAMP_W-1:0]  samp_r [NUM_CH];
  logic signed [GAIN_W-1:0]  gain_r [NUM_CH];
  logic signed [ACC_W-1:0]   acc_r;
  logic                      s_ready_r;
  logic                      cfg_ready_r;
  logic                      m_valid_r;
  logic [SAMP_W-1:0]         m_data_r;
  logic                      m_sat_r;

  logic                      s_hs_s;
  logic                      cfg_hs_s;
  logic                      mul_vld_s;
  logic signed [SAMP_W-1:0]  mul_a_s;
  logic signed [GAIN_W-1:0]  mul_b_s;
  logic                      prod_vld_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   rnd_sum_s;
  logic signed [ACC_W-1:0]   shifted_s;
  logic [SAMP_W-1:0]         sat_data_s;
  logic                      sat_clip_s;

  assign s_hs_s     = s_valid && s_ready_r;
  assign cfg_hs_s   = cfg_valid && cfg_ready_r;
  assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};

  assign s_ready    = s_ready_r;
  assign cfg_ready  = cfg_ready_r;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign m_sat      = m_sat_r;

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (s_hs_s) begin
          state_nxt_s = ST_MAC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (ch_r == CH_W'(NUM_CH - 1)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_MAC;
        end
      end
      ST_DRAIN: state_nxt_s = ST_SAT;
      ST_SAT:   state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (m_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Multiplier issue: one channel per MAC cycle.
  always_comb begin
    mul_vld_s = 1'b0;
    mul_a_s   = samp_r[ch_r];
    mul_b_s   = gain_r[ch_r];
    case (state_r)
      ST_MAC:  mul_vld_s = 1'b1;
      default: mul_vld_s = 1'b0;
    endcase
  end

  mixer_mul_reg #(
    .A_W (SAMP_W),
    .B_W (GAIN_W),
    .P_W (PROD_W)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .in_valid  (mul_vld_s),
    .a         (mul_a_s),
    .b         (mul_b_s),
    .out_valid (prod_vld_s),
    .p         (prod_s)
  );

  // Handshake flags registered from the next state so they never glitch.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s_ready_r   <= 1'b1;
      cfg_ready_r <= 1'b1;
      m_valid_r   <= 1'b0;
    end else begin
      s_ready_r   <= (state_nxt_s == ST_IDLE);
      cfg_ready_r <= (state_nxt_s == ST_IDLE);
      m_valid_r   <= (state_nxt_s == ST_OUT);
    end
  end

  // Gain file; a write in the accept cycle lands before the first MAC read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        gain_r[k] <= {GAIN_W{1'b0}};
      end
    end else if (cfg_hs_s) begin
      gain_r[cfg_ch] <= cfg_gain;
    end
  end

  // Sample latch, channel counter and accumulator.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        samp_r[k] <= {SAMP_W{1'b0}};
      end
      ch_r  <= {CH_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else if (s_hs_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        samp_r[k] <= s_samples[k*SAMP_W +: SAMP_W];
      end
      ch_r  <= {CH_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else begin
      if (state_r == ST_MAC) begin
        ch_r <= ch_r + CH_W'(1);
      end
      if (prod_vld_s) begin
        acc_r <= acc_r + prod_ext_s;
      end
    end
  end

  // Round half up, drop fraction bits, clamp to the sample range.
  always_comb begin
    rnd_sum_s = acc_r + RND;
    shifted_s = rnd_sum_s >>> GAIN_FRAC;
    if (shifted_s > SAT_HI) begin
      sat_data_s = SAT_HI[SAMP_W-1:0];
      sat_clip_s = 1'b1;
    end else if (shifted_s < SAT_LO) begin
      sat_data_s = SAT_LO[SAMP_W-1:0];
      sat_clip_s = 1'b1;
    end else begin
      sat_data_s = shifted_s[SAMP_W-1:0];
      sat_clip_s = 1'b0;
    end
  end

  // Result register, loaded once per frame and held through OUT.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_data_r <= {SAMP_W{1'b0}};
      m_sat_r  <= 1'b0;
    end else if (state_r == ST_SAT) begin
      m_data_r <= sat_data_s;
      m_sat_r  <= sat_clip_s;
    end
  end

endmodule
